mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_arith.sv | 44 ++++
 rtl/mult_div_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default latencies and a counter-width helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Down-counter width: wide enough for the longest latency, never below 4 bits.
  function automatic int cnt_width(input int max_cycles);
    int w;
    w = $clog2(max_cycles + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: full 64-bit {HI,LO} result for the four arithmetic
// ops, plus a flag marking a divide by zero so the caller can skip the commit.
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] result_o,
  output logic        div_zero_o
);

  logic signed [63:0] prod_s;

  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});

  always_comb begin
    result_o   = '0;
    div_zero_o = 1'b0;
    case (op_i)
      OP_MULT:  result_o = prod_s;
      OP_MULTU: result_o = {32'h0, a_i} * {32'h0, b_i};
      OP_DIV: begin
        if (b_i == 32'h0) begin
          div_zero_o = 1'b1;
        // The one quotient that overflows 32 bits wraps to the dividend.
        end else if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
          result_o = {32'h0, 32'h8000_0000};
        end else begin
          result_o = {$signed(a_i) % $signed(b_i), $signed(a_i) / $signed(b_i)};
        end
      end
      OP_DIVU: begin
        if (b_i == 32'h0) begin
          div_zero_o = 1'b1;
        end else begin
          result_o = {a_i % b_i, a_i / b_i};
        end
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide unit: a two-state FSM holds operands for a
// fixed latency, then commits the precomputed result into HI/LO.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_sel,
  output logic        busy,
  output logic [31:0] HIorLO_E
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = cnt_width(MAXC);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  mdu_state_e  state_q;
  logic [CW-1:0] cnt_q;
  mdu_op_e     op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [63:0] result;
  logic        div_zero;

  mdu_arith u_arith (
    .op_i       (op_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .result_o   (result),
    .div_zero_o (div_zero)
  );

  // Starts are only looked at in IDLE, so a request during BUSY is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (mdu_op_e'(op))
              OP_MULT, OP_MULTU: begin
                op_q    <= mdu_op_e'(op);
                a_q     <= a;
                b_q     <= b;
                cnt_q   <= MULT_LOAD;
                state_q <= ST_BUSY;
              end
              OP_DIV, OP_DIVU: begin
                op_q    <= mdu_op_e'(op);
                a_q     <= a;
                b_q     <= b;
                cnt_q   <= DIV_LOAD;
                state_q <= ST_BUSY;
              end
              OP_MTHI: hi_q <= a;
              OP_MTLO: lo_q <= a;
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          // Count of 1 marks the Nth busy edge: commit and return to IDLE.
          if (cnt_q == CW'(1)) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            if (!div_zero) begin
              hi_q <= result[63:32];
              lo_q <= result[31:0];
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state_q == ST_BUSY);
  assign HIorLO_E = hilo_sel ? hi_q : lo_q;

endmodule
